pic_priority_scheduler: RTL and testbench

- Interrupt request/in-service scheduler for the 8259-style PIC.
- Latches IR0..IR7 into the IRR (interrupt request register) and resolves priority against the mask and the ISR (in-service register), in fully-nested or rotating mode.
- Raises INTERNAL_INT to the control unit and supplies IR_NUM across the two-pulse INTA sequence.
- Handles AEOI, non-specific EOI and specific EOI, including rotate-on-EOI.

---
 rtl/pic_priority_scheduler.sv | 113 +++++++++++
 tb/tb_pic_priority_scheduler.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/pic_priority_scheduler.sv
// pic_priority_scheduler: 8259-style IRR/ISR priority resolution and INTA sequencing
module pic_priority_scheduler #(
    parameter logic [2:0] RESET_PRI_LOW = 3'd7,
    parameter logic [2:0] SPURIOUS_IR   = 3'd7
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] IR,
    input  logic       LEVEL,
    input  logic [7:0] interrupt_mask,
    input  logic       R,
    input  logic       AEOI,
    input  logic       INTA_PULSE,
    input  logic       EOI_STB,
    input  logic       EOI_SPECIFIC,
    input  logic [2:0] EOI_LEVEL,
    output logic       INTERNAL_INT,
    output logic [2:0] IR_NUM,
    output logic [7:0] IRR,
    output logic [7:0] ISR,
    output logic [1:0] INTA_COUNT
);
    typedef enum logic [1:0] {IDLE, REQ, ACK} state_t;

    state_t     state;
    logic [2:0] pri_low;
    logic [7:0] ir_prev;
    logic       spurious;
    logic [3:0] elig_top;
    logic [3:0] isr_top;
    logic       win;
    logic       eoi_hit;
    logic [2:0] eoi_lvl;
    logic       aeoi_hit;
    logic [7:0] set_oh;
    logic [7:0] clr;
    logic [7:0] irr_nxt;
    logic [7:0] isr_nxt;
    logic [2:0] pri_nxt;

    // {found, level} of the highest-priority set bit; level low+1 ranks first
    function automatic logic [3:0] top_level(input logic [7:0] v, input logic [2:0] low);
        logic [3:0] r;
        logic [2:0] l;
        r = '0;
        for (int i = 7; i >= 0; i--) begin
            l = low + 3'(i) + 3'd1;
            if (v[l]) r = {1'b1, l};
        end
        return r;
    endfunction

    // 0 = highest priority, 7 = lowest
    function automatic logic [2:0] rank(input logic [2:0] l, input logic [2:0] low);
        return l - low - 3'd1;
    endfunction

    // priority resolution, EOI/AEOI clears and next-state of the request registers
    always_comb begin
        elig_top = top_level(IRR & ~interrupt_mask, pri_low);
        isr_top  = top_level(ISR, pri_low);
        win      = elig_top[3] && (!isr_top[3] || rank(elig_top[2:0], pri_low) < rank(isr_top[2:0], pri_low));
        set_oh   = (state == REQ && INTA_PULSE && win) ? 8'd1 << elig_top[2:0] : 8'd0;
        eoi_lvl  = EOI_SPECIFIC ? EOI_LEVEL : isr_top[2:0];
        eoi_hit  = EOI_STB && (EOI_SPECIFIC ? ISR[EOI_LEVEL] : isr_top[3]);
        aeoi_hit = state == ACK && INTA_PULSE && AEOI && !spurious && ISR[IR_NUM];
        clr      = (eoi_hit ? 8'd1 << eoi_lvl : 8'd0) | (aeoi_hit ? 8'd1 << IR_NUM : 8'd0);
        irr_nxt  = (LEVEL ? IR : IRR | (IR & ~ir_prev)) & ~set_oh;
        isr_nxt  = (ISR & ~clr) | set_oh;
        pri_nxt  = !R ? pri_low : eoi_hit ? eoi_lvl : aeoi_hit ? IR_NUM : pri_low;
    end

    // register update and the IDLE -> REQ -> ACK acknowledge sequence
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            IRR          <= '0;
            ISR          <= '0;
            pri_low      <= RESET_PRI_LOW;
            ir_prev      <= '0;
            state        <= IDLE;
            INTERNAL_INT <= 1'b0;
            IR_NUM       <= '0;
            INTA_COUNT   <= '0;
            spurious     <= 1'b0;
        end else begin
            IRR     <= irr_nxt;
            ISR     <= isr_nxt;
            pri_low <= pri_nxt;
            ir_prev <= IR;
            case (state)
                IDLE: begin
                    INTERNAL_INT <= win;
                    if (win) begin
                        state      <= REQ;
                        INTA_COUNT <= 2'd0;
                    end
                end
                REQ: if (INTA_PULSE) begin
                    IR_NUM     <= win ? elig_top[2:0] : SPURIOUS_IR;
                    spurious   <= !win;
                    INTA_COUNT <= 2'd1;
                    state      <= ACK;
                end
                ACK: if (INTA_PULSE) begin
                    INTERNAL_INT <= 1'b0;
                    INTA_COUNT   <= 2'd2;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pic_priority_scheduler.sv
// tb_pic_priority_scheduler: directed and random checks against a behavioural PIC model
module tb_pic_priority_scheduler;
    localparam logic [2:0] SPUR = 3'd7;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [7:0] IR = '0;
    logic       LEVEL = 1'b0;
    logic [7:0] interrupt_mask = '0;
    logic       R = 1'b0;
    logic       AEOI = 1'b0;
    logic       INTA_PULSE = 1'b0;
    logic       EOI_STB = 1'b0;
    logic       EOI_SPECIFIC = 1'b0;
    logic [2:0] EOI_LEVEL = '0;
    logic       INTERNAL_INT;
    logic [2:0] IR_NUM;
    logic [7:0] IRR;
    logic [7:0] ISR;
    logic [1:0] INTA_COUNT;

    int tests = 0;
    int fails = 0;

    logic [7:0] m_irr, m_isr, m_prev;
    int         m_pl, m_st;
    logic       m_int, m_spur;
    logic [2:0] m_num;
    logic [1:0] m_cnt;

    pic_priority_scheduler dut (
        .CLK(CLK), .RST(RST), .IR(IR), .LEVEL(LEVEL), .interrupt_mask(interrupt_mask),
        .R(R), .AEOI(AEOI), .INTA_PULSE(INTA_PULSE), .EOI_STB(EOI_STB),
        .EOI_SPECIFIC(EOI_SPECIFIC), .EOI_LEVEL(EOI_LEVEL), .INTERNAL_INT(INTERNAL_INT),
        .IR_NUM(IR_NUM), .IRR(IRR), .ISR(ISR), .INTA_COUNT(INTA_COUNT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // distance below the top of the cyclic order: 0 = highest priority
    function automatic int prio(input int l, input int pl);
        return (l - pl + 15) % 8;
    endfunction

    function automatic int best(input logic [7:0] v, input int pl);
        int b = -1;
        for (int l = 0; l < 8; l++)
            if (v[l] && (b < 0 || prio(l, pl) < prio(b, pl))) b = l;
        return b;
    endfunction

    task automatic mreset;
        m_irr = '0; m_isr = '0; m_prev = '0; m_pl = 7; m_st = 0;
        m_int = 0; m_spur = 0; m_num = '0; m_cnt = '0;
    endtask

    task automatic mstep;
        int w, t, rot;
        logic win;
        logic [7:0] irr_n, isr_n;
        w = best(m_irr & ~interrupt_mask, m_pl);
        t = best(m_isr, m_pl);
        win = w >= 0 && (t < 0 || prio(w, m_pl) < prio(t, m_pl));
        irr_n = LEVEL ? IR : (m_irr | (IR & ~m_prev));
        isr_n = m_isr;
        rot = -1;
        if (EOI_STB) begin
            if (EOI_SPECIFIC) begin
                if (m_isr[EOI_LEVEL]) begin isr_n[EOI_LEVEL] = 1'b0; rot = int'(EOI_LEVEL); end
            end else if (t >= 0) begin
                isr_n[t] = 1'b0; rot = t;
            end
        end
        if (m_st == 0) begin
            m_int = win;
            if (win) begin m_st = 1; m_cnt = 0; end
        end else if (m_st == 1) begin
            if (INTA_PULSE) begin
                if (win) begin m_num = 3'(w); isr_n[w] = 1'b1; irr_n[w] = 1'b0; m_spur = 0; end
                else begin m_num = SPUR; m_spur = 1; end
                m_cnt = 1; m_st = 2;
            end
        end else if (INTA_PULSE) begin
            m_int = 0; m_cnt = 2; m_st = 0;
            if (AEOI && !m_spur && m_isr[m_num]) begin
                isr_n[m_num] = 1'b0;
                if (rot < 0) rot = int'(m_num);
            end
        end
        if (R && rot >= 0) m_pl = rot;
        m_irr = irr_n; m_isr = isr_n; m_prev = IR;
    endtask

    task automatic cyc;
        @(posedge CLK);
        mstep();
        #1;
        chk("int", INTERNAL_INT, m_int);
        chk("ir_num", IR_NUM, m_num);
        chk("irr", IRR, m_irr);
        chk("isr", ISR, m_isr);
        chk("inta_count", INTA_COUNT, m_cnt);
    endtask

    task automatic inta_pair;
        INTA_PULSE = 1; cyc(); INTA_PULSE = 0; cyc();
        INTA_PULSE = 1; cyc(); INTA_PULSE = 0;
    endtask

    task automatic eoi_ns;
        EOI_STB = 1; EOI_SPECIFIC = 0; cyc(); EOI_STB = 0;
    endtask

    initial begin
        #2 RST = 1;
        #1;
        chk("rst_int", INTERNAL_INT, 0);
        chk("rst_num", IR_NUM, 0);
        chk("rst_irr", IRR, 0);
        chk("rst_isr", ISR, 0);
        chk("rst_cnt", INTA_COUNT, 0);
        mreset();
        repeat (2) @(posedge CLK);
        #1 RST = 0;

        // fully nested, simultaneous IR2 and IR5
        IR = 8'h24; cyc(); cyc();
        chk("t1_int", INTERNAL_INT, 1);
        IR = 8'h00; inta_pair();
        chk("t1_num", IR_NUM, 2); chk("t1_isr", ISR, 8'h04);
        chk("t1_irr", IRR, 8'h20); chk("t1_cnt", INTA_COUNT, 2);
        repeat (3) cyc();
        chk("t1_blocked", INTERNAL_INT, 0);
        eoi_ns(); cyc();
        chk("t1_reint", INTERNAL_INT, 1);
        inta_pair();
        chk("t1_num5", IR_NUM, 5); chk("t1_isr5", ISR, 8'h20);
        eoi_ns(); cyc();

        // latency and blocking by a higher-priority in-service level
        IR = 8'h08; cyc();
        chk("t2_irr", IRR, 8'h08); chk("t2_int0", INTERNAL_INT, 0);
        cyc();
        chk("t2_int1", INTERNAL_INT, 1);
        inta_pair();
        IR = 8'h48; repeat (3) cyc();
        chk("t2_blk_int", INTERNAL_INT, 0); chk("t2_blk_irr", IRR, 8'h40);
        eoi_ns(); cyc(); inta_pair();
        chk("t2_num6", IR_NUM, 6);
        eoi_ns(); IR = 8'h00; cyc();

        // specific EOI and EOI coinciding with INTA #1
        IR = 8'h08; cyc(); cyc(); inta_pair();
        IR = 8'h0A; cyc(); cyc(); inta_pair();
        chk("t5_isr0a", ISR, 8'h0A);
        EOI_STB = 1; EOI_SPECIFIC = 1; EOI_LEVEL = 3; cyc();
        EOI_STB = 0; EOI_SPECIFIC = 0;
        chk("t5_isr02", ISR, 8'h02);
        IR = 8'h0B; cyc(); cyc();
        EOI_STB = 1; INTA_PULSE = 1; cyc();
        EOI_STB = 0; INTA_PULSE = 0;
        chk("t5_isr01", ISR, 8'h01);
        cyc(); INTA_PULSE = 1; cyc(); INTA_PULSE = 0;
        chk("t5_num0", IR_NUM, 0);
        eoi_ns(); IR = 8'h00; cyc();

        // level mode request withdrawn before INTA #1
        LEVEL = 1; IR = 8'h02; cyc(); cyc();
        chk("t4_int", INTERNAL_INT, 1);
        IR = 8'h00; cyc(); inta_pair();
        chk("t4_num", IR_NUM, 7); chk("t4_isr", ISR, 0); chk("t4_irr", IRR, 0);
        LEVEL = 0; cyc();

        // rotating priority with automatic EOI
        R = 1; AEOI = 1;
        IR = 8'h10; cyc(); cyc(); inta_pair();
        chk("t3_num4", IR_NUM, 4); chk("t3_isr", ISR, 0);
        IR = 8'h41; cyc(); cyc(); inta_pair();
        chk("t3_num6", IR_NUM, 6); chk("t3_irr", IRR, 8'h01);
        cyc(); inta_pair();
        chk("t3_num0", IR_NUM, 0);
        R = 0; AEOI = 0; IR = 8'h00; cyc();

        // asynchronous reset while in ACK
        IR = 8'h01; cyc(); cyc();
        INTA_PULSE = 1; cyc(); INTA_PULSE = 0;
        #2 RST = 1;
        #1;
        chk("t6_int", INTERNAL_INT, 0); chk("t6_num", IR_NUM, 0);
        chk("t6_irr", IRR, 0); chk("t6_isr", ISR, 0); chk("t6_cnt", INTA_COUNT, 0);
        mreset();
        #2 RST = 0;
        IR = 8'h00; cyc();
        IR = 8'h01; cyc(); cyc();
        chk("t6_reint", INTERNAL_INT, 1);
        inta_pair();
        chk("t6_num0", IR_NUM, 0); chk("t6_isr01", ISR, 8'h01);
        eoi_ns();

        // randomized traffic against the model
        for (int n = 0; n < 800; n++) begin
            if (n % 50 == 0) begin
                LEVEL = 1'($urandom); R = 1'($urandom); AEOI = 1'($urandom);
            end
            if (n % 20 == 0) interrupt_mask = 8'($urandom) & 8'($urandom);
            IR = IR ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
            INTA_PULSE = $urandom_range(0, 3) == 0;
            EOI_STB = $urandom_range(0, 7) == 0;
            EOI_SPECIFIC = 1'($urandom);
            EOI_LEVEL = 3'($urandom);
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
